// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : morse_pkg
//  Description : Shared types, pattern table and defaults for morse_sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } morse_state_t;

  typedef struct packed {
    logic [11:0] pattern;
    logic [3:0]  length;
  } morse_sym_t;

  localparam int C_DEFAULT_GAP_LEN = 3;

  // Patterns are MSB-first and left-justified; length counts symbol times.
  function automatic morse_sym_t morse_lookup(input logic [2:0] code);
    morse_sym_t s;
    s = '0;
    case (code)
      3'd0: s = '{pattern: 12'hB80, length: 4'd5};
      3'd1: s = '{pattern: 12'hEA8, length: 4'd9};
      3'd2: s = '{pattern: 12'hEBA, length: 4'd11};
      3'd3: s = '{pattern: 12'hEA0, length: 4'd7};
      3'd4: s = '{pattern: 12'h800, length: 4'd1};
      3'd5: s = '{pattern: 12'hAE8, length: 4'd9};
      3'd6: s = '{pattern: 12'hEE8, length: 4'd9};
      3'd7: s = '{pattern: 12'hAA0, length: 4'd7};
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/morse_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : morse_sequencer_if
//  Description : Letter valid/ready handshake between producer and sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
interface morse_sequencer_if;
  logic [2:0] Letter;
  logic       LetterValid;
  logic       LetterReady;

  modport master (output Letter, output LetterValid, input LetterReady);
  modport slave  (input Letter, input LetterValid, output LetterReady);
endinterface
`default_nettype wire

// File: rtl/morse_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : morse_fifo
//  Description : DEPTH x 3-bit first-word-fall-through FIFO with sync flush.
//  Revision    : 1.0  initial release
// ============================================================================
module morse_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       ClockIn,
  input  logic       Resetn,
  input  logic       i_flush,
  input  logic       i_push,
  input  logic [2:0] i_wdata,
  input  logic       i_pop,
  output logic [2:0] o_rdata,
  output logic       o_full,
  output logic       o_empty
);

  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_AW:0] c_FULL = (c_AW+1)'(DEPTH);

  logic [2:0]      r_mem [DEPTH];
  logic [c_AW-1:0] r_wptr;
  logic [c_AW-1:0] r_rptr;
  logic [c_AW:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == c_FULL);
  assign o_empty = (r_count == '0);
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (w_push) r_wptr <= r_wptr + c_AW'(1);
      if (w_pop)  r_rptr <= r_rptr + c_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_AW+1)'(1);
        2'b01:   r_count <= r_count - (c_AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge ClockIn) begin
    if (w_push && !i_flush) r_mem[r_wptr] <= i_wdata;
  end

endmodule
`default_nettype wire

// File: rtl/morse_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : morse_sequencer
//  Description : Queued Morse letter player: FIFO, tick divider, send/gap FSM.
//  Revision    : 1.0  initial release
// ============================================================================
module morse_sequencer
  import morse_pkg::*;
#(
  parameter int TICK_DIV = 250,
  parameter int DEPTH    = 4,
  parameter int GAP_LEN  = C_DEFAULT_GAP_LEN
) (
  input  logic              ClockIn,
  input  logic              Resetn,
  morse_sequencer_if.slave  lbus,
  input  logic              Abort,
  output logic              DotDashOut,
  output logic              Busy,
  output logic              Done
);

  localparam int c_TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_GW = $clog2(GAP_LEN + 1);
  localparam logic [c_TW-1:0] c_TICK_RELOAD = c_TW'(TICK_DIV - 1);
  localparam logic [c_GW-1:0] c_GAP_RELOAD  = c_GW'(GAP_LEN);

  morse_state_t    r_state;
  logic [c_TW-1:0] r_tick_cnt;
  logic [11:0]     r_shift;
  logic [3:0]      r_rem;
  logic [c_GW-1:0] r_gap;
  logic            r_dot;
  logic            r_done;

  logic       w_full;
  logic       w_empty;
  logic [2:0] w_rdata;
  logic       w_tick;
  logic       w_gap_end;
  logic       w_pop;
  morse_sym_t w_sym;

  morse_fifo #(.DEPTH(DEPTH)) u_fifo (
    .ClockIn (ClockIn),
    .Resetn  (Resetn),
    .i_flush (Abort),
    .i_push  (lbus.LetterValid),
    .i_wdata (lbus.Letter),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign lbus.LetterReady = !w_full;
  assign w_tick    = (r_tick_cnt == '0);
  assign w_gap_end = (r_state == ST_GAP) && w_tick && (r_gap == c_GW'(1));
  // A pop is also a letter load; abort suppresses it and flushes instead.
  assign w_pop     = !Abort && !w_empty && ((r_state == ST_IDLE) || w_gap_end);
  assign w_sym     = morse_lookup(w_rdata);

  assign DotDashOut = r_dot;
  assign Busy       = (r_state != ST_IDLE);
  assign Done       = r_done;

  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) begin
      r_state    <= ST_IDLE;
      r_tick_cnt <= c_TICK_RELOAD;
      r_shift    <= '0;
      r_rem      <= '0;
      r_gap      <= '0;
      r_dot      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (Abort) begin
        r_state    <= ST_IDLE;
        r_tick_cnt <= c_TICK_RELOAD;
        r_shift    <= '0;
        r_dot      <= 1'b0;
      end else begin
        r_tick_cnt <= w_tick ? c_TICK_RELOAD : (r_tick_cnt - c_TW'(1));
        if (w_pop) begin
          // Reloading the divider makes the first symbol full length.
          r_state    <= ST_SEND;
          r_shift    <= w_sym.pattern;
          r_rem      <= w_sym.length;
          r_dot      <= w_sym.pattern[11];
          r_tick_cnt <= c_TICK_RELOAD;
        end else begin
          case (r_state)
            ST_SEND: begin
              if (w_tick) begin
                r_shift <= {r_shift[10:0], 1'b0};
                r_rem   <= r_rem - 4'd1;
                if (r_rem == 4'd1) begin
                  r_state <= ST_GAP;
                  r_gap   <= c_GAP_RELOAD;
                  r_dot   <= 1'b0;
                end else begin
                  r_dot <= r_shift[10];
                end
              end
            end
            ST_GAP: begin
              r_dot <= 1'b0;
              if (w_tick) begin
                r_gap <= r_gap - c_GW'(1);
                if (r_gap == c_GW'(1)) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b1;
                end
              end
            end
            default: begin
              r_state <= ST_IDLE;
              r_dot   <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_morse_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_morse_sequencer
//  Description : Directed self-checking bench for morse_sequencer (two configs).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_morse_sequencer;

  localparam int GAP = 3;

  logic clk;
  logic Resetn;
  logic abort;
  logic dot4, busy4, done4;
  logic dot2, busy2, done2;

  int n_vec;
  int n_err;
  int msg[$];
  string pats[8];

  morse_sequencer_if bus4 ();
  morse_sequencer_if bus2 ();

  morse_sequencer #(.TICK_DIV(4), .DEPTH(4), .GAP_LEN(GAP)) dut4 (
    .ClockIn(clk), .Resetn(Resetn), .lbus(bus4.slave), .Abort(abort),
    .DotDashOut(dot4), .Busy(busy4), .Done(done4)
  );

  morse_sequencer #(.TICK_DIV(2), .DEPTH(2), .GAP_LEN(GAP)) dut2 (
    .ClockIn(clk), .Resetn(Resetn), .lbus(bus2.slave), .Abort(1'b0),
    .DotDashOut(dot2), .Busy(busy2), .Done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic s_dot(input bit sel);   return sel ? dot2 : dot4;   endfunction
  function automatic logic s_busy(input bit sel);  return sel ? busy2 : busy4; endfunction
  function automatic logic s_done(input bit sel);  return sel ? done2 : done4; endfunction
  function automatic logic s_ready(input bit sel); return sel ? bus2.LetterReady : bus4.LetterReady; endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit sel, input logic [2:0] code, input logic v);
    if (sel) begin
      bus2.Letter = code; bus2.LetterValid = v;
    end else begin
      bus4.Letter = code; bus4.LetterValid = v;
    end
  endtask

  // Offer a letter, wait (bounded) for ready, then let one edge accept it.
  task automatic push(input bit sel, input logic [2:0] code);
    int waited;
    waited = 0;
    set_in(sel, code, 1'b1);
    while (!s_ready(sel) && waited < 400) begin
      cyc();
      waited++;
    end
    check("push_ready", s_ready(sel), 1'b1);
    cyc();
    set_in(sel, 3'd0, 1'b0);
  endtask

  task automatic expect_cycle(input bit sel, input logic b);
    cyc();
    check("wave", s_dot(sel), b);
    check("busy_hi", s_busy(sel), 1'b1);
    check("done_lo", s_done(sel), 1'b0);
  endtask

  // Expected per-cycle waveform for the letters in msg, starting at the load edge.
  task automatic run_expect(input bit sel);
    int td;
    string p;
    td = sel ? 2 : 4;
    foreach (msg[k]) begin
      p = pats[msg[k]];
      for (int j = 0; j < p.len(); j++)
        repeat (td) expect_cycle(sel, p.getc(j) == "1");
      repeat (GAP * td) expect_cycle(sel, 1'b0);
    end
    cyc();
    check("done_pulse", s_done(sel), 1'b1);
    check("busy_fall", s_busy(sel), 1'b0);
    check("dot_idle", s_dot(sel), 1'b0);
    cyc();
    check("done_clear", s_done(sel), 1'b0);
  endtask

  task automatic send_msg(input bit sel, input int full_at);
    push(sel, 3'(msg[0]));
    fork
      begin
        for (int i = 1; i < msg.size(); i++) begin
          push(sel, 3'(msg[i]));
          if (i == full_at) check("ready_full", s_ready(sel), 1'b0);
        end
      end
      run_expect(sel);
    join
  endtask

  task automatic idle_hold(input string tag, input int n);
    repeat (n) begin
      cyc();
      check(tag, busy4, 1'b0);
      check("no_done", done4, 1'b0);
    end
  endtask

  // Reset asserted between edges must clear outputs without a clock edge.
  task automatic mid_reset(input string tag);
    #3;
    Resetn = 1'b0;
    #1;
    check({tag, "_dot"}, dot4, 1'b0);
    check({tag, "_busy"}, busy4, 1'b0);
    check({tag, "_done"}, done4, 1'b0);
    check({tag, "_ready"}, bus4.LetterReady, 1'b1);
    #2;
    Resetn = 1'b1;
    cyc();
    check({tag, "_ready_after"}, bus4.LetterReady, 1'b1);
    idle_hold({tag, "_fifo_empty"}, 3);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    pats[0] = "10111";       pats[1] = "111010101";
    pats[2] = "11101011101"; pats[3] = "1110101";
    pats[4] = "1";           pats[5] = "101011101";
    pats[6] = "111011101";   pats[7] = "1010101";
    Resetn = 1'b0;
    abort  = 1'b0;
    set_in(1'b0, 3'd0, 1'b0);
    set_in(1'b1, 3'd0, 1'b0);
    #2;
    check("rst_dot", dot4, 1'b0);
    check("rst_busy", busy4, 1'b0);
    check("rst_done", done4, 1'b0);
    check("rst_ready", bus4.LetterReady, 1'b1);
    check("rst_ready2", bus2.LetterReady, 1'b1);
    cyc();
    Resetn = 1'b1;
    cyc();

    // Single E: 4 cycles high, 12 low, one Done.
    msg = {4};
    send_msg(1'b0, -1);

    // A then B back-to-back with no idle cycle between them.
    msg = {0, 1};
    send_msg(1'b0, -1);

    // Six letters: four buffered behind E fill the FIFO, F is retried and sent last.
    msg = {4, 0, 1, 2, 3, 5};
    send_msg(1'b0, 4);

    // Abort in C's second symbol with A and B queued; same-cycle G is dropped.
    push(1'b0, 3'd2);
    push(1'b0, 3'd0);
    push(1'b0, 3'd1);
    repeat (4) cyc();
    check("abort_pre_dot", dot4, 1'b1);
    check("abort_pre_busy", busy4, 1'b1);
    abort = 1'b1;
    set_in(1'b0, 3'd6, 1'b1);
    cyc();
    abort = 1'b0;
    set_in(1'b0, 3'd0, 1'b0);
    check("abort_dot", dot4, 1'b0);
    check("abort_busy", busy4, 1'b0);
    check("abort_done", done4, 1'b0);
    check("abort_ready", bus4.LetterReady, 1'b1);
    idle_hold("abort_fifo_empty", 4);
    msg = {7};
    send_msg(1'b0, -1);

    // Reset mid-SEND (output high) and mid-GAP, each with a letter queued.
    push(1'b0, 3'd4);
    push(1'b0, 3'd0);
    check("pre_rst_send", dot4, 1'b1);
    mid_reset("rst_send");
    push(1'b0, 3'd4);
    push(1'b0, 3'd0);
    repeat (6) cyc();
    check("pre_rst_gap_busy", busy4, 1'b1);
    check("pre_rst_gap_dot", dot4, 1'b0);
    mid_reset("rst_gap");

    // DEPTH=2, TICK_DIV=2: simultaneous push/pop at count 1, order across wrap.
    msg = {5, 6, 7, 0, 3};
    send_msg(1'b1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
